// File: rtl/mips_pkg.sv
// Shared pipeline definitions: fixed instruction encodings and the fetch queue entry layout.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle around the fetch queue; the queue uses the slave side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   instr_IF;
    logic [31:0]   PC_4_IF;
    logic          valid_IF;
    logic          ready_IF;
    logic [31:0]   instr_ID;
    logic [31:0]   PC_4_ID;
    logic          valid_ID;
    logic          stall_ID;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output instr_IF, PC_4_IF, valid_IF, stall_ID, flush,
        input  ready_IF, instr_ID, PC_4_ID, valid_ID, count
    );

    modport slave (
        input  instr_IF, PC_4_IF, valid_IF, stall_ID, flush,
        output ready_IF, instr_ID, PC_4_ID, valid_ID, count
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x 64-bit entry storage: one synchronous write port, one asynchronous read port, no reset.
module fetch_queue_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode; redirects drop everything buffered.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_WORD  = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    fetch_queue_if.slave fq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic          not_full;
    fq_entry_t     wr_entry;
    fq_entry_t     head_entry;

    // Full/empty come only from the registered count, so ready_IF never depends on pop.
    assign not_empty = (count_reg != '0);
    assign not_full  = (count_reg != CW'(DEPTH));
    assign push      = fq.valid_IF & not_full & ~fq.flush;
    assign pop       = not_empty & ~fq.stall_ID & ~fq.flush;

    assign wr_entry.instr = fq.instr_IF;
    assign wr_entry.pc4   = fq.PC_4_IF;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (head_entry)
    );

    always_ff @(posedge clk) begin
        if (reset || fq.flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Empty queue shows a bubble so uninitialised storage never reaches decode.
    assign fq.valid_ID = not_empty;
    assign fq.instr_ID = not_empty ? head_entry.instr : NOP_WORD;
    assign fq.PC_4_ID  = not_empty ? head_entry.pc4   : 32'h0;
    assign fq.ready_IF = not_full;
    assign fq.count    = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, pass-through, saturation, wrap, flush and reset-over-flush.
module tb_fetch_queue;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    fetch_queue_if #(.DEPTH(4)) fq_bus ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wi(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] wp(input int k);
        return 32'h0000_4000 + 32'(4 * k);
    endfunction

    task automatic drive(input logic v, input int k);
        fq_bus.valid_IF = v;
        fq_bus.instr_IF = wi(k);
        fq_bus.PC_4_IF  = wp(k);
    endtask

    task automatic check_head(input string tag, input int k);
        check({tag, ".valid"}, 64'(fq_bus.valid_ID), 64'(1));
        check({tag, ".instr"}, 64'(fq_bus.instr_ID), 64'(wi(k)));
        check({tag, ".pc4"},   64'(fq_bus.PC_4_ID),  64'(wp(k)));
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, 64'(fq_bus.valid_ID), 64'(0));
        check({tag, ".instr"}, 64'(fq_bus.instr_ID), 64'(0));
        check({tag, ".pc4"},   64'(fq_bus.PC_4_ID),  64'(0));
        check({tag, ".ready"}, 64'(fq_bus.ready_IF), 64'(1));
        check({tag, ".count"}, 64'(fq_bus.count),    64'(0));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset           = 1'b1;
        fq_bus.valid_IF = 1'b0;
        fq_bus.instr_IF = 32'h0;
        fq_bus.PC_4_IF  = 32'h0;
        fq_bus.stall_ID = 1'b0;
        fq_bus.flush    = 1'b0;

        // 1: reset for two cycles
        step();
        step();
        reset = 1'b0;
        check_empty("t1_reset");

        // 2: single word passes straight through to decode
        fq_bus.valid_IF = 1'b1;
        fq_bus.instr_IF = 32'h2008_0001;
        fq_bus.PC_4_IF  = 32'h0000_3004;
        step();
        check("t2_valid", 64'(fq_bus.valid_ID), 64'(1));
        check("t2_instr", 64'(fq_bus.instr_ID), 64'h2008_0001);
        check("t2_pc4",   64'(fq_bus.PC_4_ID),  64'h0000_3004);
        check("t2_count", 64'(fq_bus.count),    64'(1));
        fq_bus.valid_IF = 1'b0;
        step();
        check("t2_drain_valid", 64'(fq_bus.valid_ID), 64'(0));
        check("t2_drain_count", 64'(fq_bus.count),    64'(0));

        // 3: stalled decode, five offered words, only four stored
        fq_bus.stall_ID = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, k);
            step();
            check($sformatf("t3_count_%0d", k), 64'(fq_bus.count), 64'((k < 4) ? k : 4));
            check($sformatf("t3_ready_%0d", k), 64'(fq_bus.ready_IF), 64'((k < 4) ? 1 : 0));
        end
        drive(1'b0, 0);
        fq_bus.stall_ID = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check_head($sformatf("t3_out_%0d", k), k);
            step();
        end
        check_empty("t3_empty");

        // 4: full queue with pop refuses the push, then streaming across the pointer wrap
        fq_bus.stall_ID = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            drive(1'b1, k);
            step();
        end
        check("t4_full_count", 64'(fq_bus.count), 64'(4));
        fq_bus.stall_ID = 1'b0;
        drive(1'b1, 15);
        check("t4_full_ready", 64'(fq_bus.ready_IF), 64'(0));
        step();
        check("t4_pop_only_count", 64'(fq_bus.count), 64'(3));
        check_head("t4_pop_only_head", 12);
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 15 + j);
            step();
            check($sformatf("t4_stream_count_%0d", j), 64'(fq_bus.count), 64'(3));
            check_head($sformatf("t4_stream_%0d", j), 13 + j);
        end
        drive(1'b0, 0);
        for (int k = 22; k <= 24; k++) begin
            check_head($sformatf("t4_drain_%0d", k), k);
            step();
        end
        check_empty("t4_empty");

        // 5: flush at count 3 discards both the buffer and the incoming word
        fq_bus.stall_ID = 1'b1;
        for (int k = 31; k <= 33; k++) begin
            drive(1'b1, k);
            step();
        end
        check("t5_pre_count", 64'(fq_bus.count), 64'(3));
        fq_bus.stall_ID = 1'b0;
        fq_bus.flush    = 1'b1;
        drive(1'b1, 34);
        step();
        fq_bus.flush = 1'b0;
        drive(1'b0, 0);
        check_empty("t5_flushed");
        step();
        check_empty("t5_after");
        fq_bus.stall_ID = 1'b1;
        drive(1'b1, 35);
        step();
        check_head("t5_next_head", 35);

        // 6: reset and flush together with a push at count 2
        drive(1'b1, 36);
        step();
        check("t6_pre_count", 64'(fq_bus.count), 64'(2));
        reset        = 1'b1;
        fq_bus.flush = 1'b1;
        drive(1'b1, 37);
        step();
        reset        = 1'b0;
        fq_bus.flush = 1'b0;
        drive(1'b0, 0);
        check_empty("t6_reset");
        check("t6_no_x", 64'($isunknown({fq_bus.valid_ID, fq_bus.instr_ID, fq_bus.PC_4_ID,
                                         fq_bus.ready_IF, fq_bus.count})), 64'(0));
        step();
        check_empty("t6_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
